// File: rtl/rapcores_spi_host_pkg.sv
// Shared types for the RAPcores SPI host.
// FSM state encoding and chip-select decode.
package rapcores_spi_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_LINGER,
        ST_HOLD,
        ST_GAP
    } state_e;

    // CS is driven low in every state that belongs to an open transaction
    function automatic logic cs_active(input state_e s);
        return (s == ST_SETUP) || (s == ST_SHIFT) ||
               (s == ST_LINGER) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/rapcores_spi_host_sck_gen.sv
// SCK divider for the RAPcores SPI host.
// Toggles SCK every CLK_DIV cycles; strobes mark the edge about to happen.
module rapcores_spi_host_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          ph_q, ph_d;
    logic          wrap;

    assign wrap   = (div_q == DW'(CLK_DIV - 1));
    assign rise_o = en_i && !clr_i && wrap && !ph_q;
    assign fall_o = en_i && !clr_i && wrap && ph_q;
    assign sck_o  = ph_q;

    // divider next state; clear forces SCK low and restarts the half-period
    always_comb begin
        div_d = div_q;
        ph_d  = ph_q;
        if (clr_i) begin
            div_d = '0;
            ph_d  = 1'b0;
        end else if (en_i) begin
            if (wrap) begin
                div_d = '0;
                ph_d  = !ph_q;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    // divider registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            ph_q  <= ph_d;
        end
    end

endmodule

// File: rtl/rapcores_spi_host.sv
// RAPcores SPI host: mode 0, MSB first, valid/ready word stream.
// Kept words share one CS-low window; abort drops the partial word.
module rapcores_spi_host
    import rapcores_spi_host_pkg::*;
#(
    parameter int WORD_BITS = 64,
    parameter int CLK_DIV   = 2,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_GAP    = 4
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_keep,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 abort,
    output logic                 busy,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
);

    localparam int BW   = $clog2(WORD_BITS);
    localparam int TMAX = (CS_SETUP > CS_HOLD) ?
                          ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                          ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int TW   = $clog2(TMAX + 1);

    state_e                 state_q, state_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [WORD_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic [WORD_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic [WORD_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   keep_q, keep_d;
    logic                   sync1_q, sync2_q;
    logic                   accept;
    logic                   sck_en, sck_clr;
    logic                   sck_rise, sck_fall;

    assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_LINGER);
    assign accept   = tx_valid && tx_ready;
    assign sck_en   = (state_q == ST_SHIFT) && !abort;
    assign sck_clr  = !sck_en;
    assign CS       = !cs_active(state_q);
    assign busy     = (state_q != ST_IDLE);
    assign COPI     = tx_sh_q[WORD_BITS-1];
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    rapcores_spi_host_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck (
        .clk_i (CLK),
        .rst_ni(resetn),
        .en_i  (sck_en),
        .clr_i (sck_clr),
        .sck_o (SCK),
        .rise_o(sck_rise),
        .fall_o(sck_fall)
    );

    // two-flop synchroniser on the peripheral data input
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= CIPO;
            sync2_q <= sync1_q;
        end
    end

    // transaction FSM, shift registers and phase timers
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        keep_d     = keep_q;
        if (abort && cs_active(state_q)) begin
            state_d = ST_GAP;
            tmr_d   = '0;
            bit_d   = '0;
            tx_sh_d = '0;
            rx_sh_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tx_sh_d = tx_data;
                        keep_d  = tx_keep;
                        tmr_d   = '0;
                        bit_d   = '0;
                        state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_q == TW'(CS_SETUP - 1)) begin
                        tmr_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        rx_sh_d = {rx_sh_q[WORD_BITS-2:0], sync2_q};
                    end
                    if (sck_fall) begin
                        if (bit_q == BW'(WORD_BITS - 1)) begin
                            bit_d      = '0;
                            tmr_d      = '0;
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_sh_q;
                            state_d    = keep_q ? ST_LINGER : ST_HOLD;
                        end else begin
                            bit_d   = bit_q + BW'(1);
                            tx_sh_d = tx_sh_q << 1;
                        end
                    end
                end
                ST_LINGER: begin
                    if (accept) begin
                        tx_sh_d = tx_data;
                        keep_d  = tx_keep;
                        bit_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (tmr_q == TW'(CS_HOLD - 1)) begin
                        tmr_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (tmr_q == TW'(CS_GAP - 1)) begin
                        tmr_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM and datapath registers
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            keep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            keep_q     <= keep_d;
        end
    end

endmodule
